jstk2_spi_responder: RTL and testbench

//  SPI slave (mode 0, MSB first) that emulates the PmodJSTK2 end of the joystick link.

---
 rtl/jstk2_spi_responder.sv | 144 ++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2-style SPI mode-0 slave: streams a 5-byte X/Y/button packet on MISO
// and decodes the master's command byte, latching RGB for the LED command.
module jstk2_spi_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter int          FRAME_BYTES = 5,
   parameter logic [7:0]  CMD_LED     = 8'h84
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        SS,
   input  logic        MOSI,
   output logic        MISO,
   output logic        miso_oe,
   input  logic [9:0]  x_pos,
   input  logic [9:0]  y_pos,
   input  logic [1:0]  btn,
   output logic [23:0] led_rgb,
   output logic        led_valid,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int BCW = $clog2(FRAME_BYTES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sy, ss_sy, mosi_sy;
   logic                   sclk_d, ss_d, fall_pend;
   logic [38:0]            tx_sh;
   logic [6:0]             rx_sh;
   logic [2:0]             bit_cnt;
   logic [BCW-1:0]         byte_cnt;
   logic [7:0]             cmd, r_b, g_b, b_b;

   logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall;
   logic [7:0] rx_byte;

   assign sclk_s    = sclk_sy[SYNC_STAGES-1];
   assign ss_s      = ss_sy[SYNC_STAGES-1];
   assign mosi_s    = mosi_sy[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_fall   = ~ss_s & ss_d;
   assign rx_byte   = {rx_sh, mosi_s};

   // SS chain resets low so a select still held low across reset never looks like a new fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sy <= '0;
         ss_sy   <= '0;
         mosi_sy <= '0;
         sclk_d  <= 1'b0;
         ss_d    <= 1'b0;
      end else begin
         sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], SCLK};
         ss_sy   <= {ss_sy[SYNC_STAGES-2:0], SS};
         mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], MOSI};
         sclk_d  <= sclk_s;
         ss_d    <= ss_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fall_pend  <= 1'b0;
         MISO       <= 1'b0;
         miso_oe    <= 1'b0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         cmd        <= '0;
         r_b        <= '0;
         g_b        <= '0;
         b_b        <= '0;
         led_rgb    <= '0;
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall || fall_pend) begin
                  fall_pend <= 1'b0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               // MSB of byte 0 goes straight to MISO; the rest waits in tx_sh.
               MISO     <= x_pos[7];
               tx_sh    <= {x_pos[6:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 6'b0, btn};
               miso_oe  <= 1'b1;
               bit_cnt  <= '0;
               byte_cnt <= '0;
               cmd      <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               // SS level checked first: a rise beats any coincident SCLK edge.
               if (ss_s) begin
                  state <= DONE;
               end else if (sclk_rise) begin
                  rx_sh   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7 && byte_cnt < BCW'(FRAME_BYTES)) begin
                     byte_cnt <= byte_cnt + BCW'(1);
                     case (byte_cnt)
                        BCW'(0): cmd <= rx_byte;
                        BCW'(1): r_b <= rx_byte;
                        BCW'(2): g_b <= rx_byte;
                        BCW'(3): b_b <= rx_byte;
                        default: ;
                     endcase
                  end
               end else if (sclk_fall) begin
                  // Zeros shift in behind the packet, so oversize frames read 0x00.
                  MISO  <= tx_sh[38];
                  tx_sh <= {tx_sh[37:0], 1'b0};
               end
            end
            DONE: begin
               MISO      <= 1'b0;
               miso_oe   <= 1'b0;
               fall_pend <= ss_fall;
               if (bit_cnt == 3'd0 && byte_cnt == BCW'(FRAME_BYTES)) frame_done <= 1'b1;
               else                                                  frame_err  <= 1'b1;
               if (cmd == CMD_LED && byte_cnt >= BCW'(4) && bit_cnt == 3'd0) begin
                  led_rgb   <= {r_b, g_b, b_b};
                  led_valid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Bench for jstk2_spi_responder: table of hand-checked frames, reset/back-to-back
// sequences, then random frames checked against a packet-level model.
module tb_jstk2_spi_responder;

   logic        clk = 1'b0, rst = 1'b1, SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0;
   logic [9:0]  x_pos = '0, y_pos = '0;
   logic [1:0]  btn = '0;
   logic        MISO, miso_oe, led_valid, frame_done, frame_err;
   logic [23:0] led_rgb;

   jstk2_spi_responder dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
      .miso_oe(miso_oe), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
      .led_rgb(led_rgb), .led_valid(led_valid), .frame_done(frame_done),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int n_done = 0, n_err = 0, n_lv = 0;

   always @(negedge clk) begin
      if (frame_done) n_done <= n_done + 1;
      if (frame_err)  n_err  <= n_err + 1;
      if (led_valid)  n_lv   <= n_lv + 1;
   end

   typedef struct {
      logic [9:0]  x, y;
      logic [1:0]  b;
      int          nbits;
      logic [63:0] mo;
      int          chg_at;
      logic [9:0]  chg_x;
      int          exp_done, exp_err, exp_lv;
      logic [23:0] exp_led;
   } vec_t;

   vec_t tbl[8];

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic xfer_bit(input logic mo, output logic mi);
      MOSI = mo;
      wclk(8);
      mi   = MISO;
      SCLK = 1'b1;
      wclk(8);
      SCLK = 1'b0;
   endtask

   task automatic run_frame(input int nbits, input logic [63:0] mo, input int chg_at,
                            input logic [9:0] chg_x, output logic [63:0] got, output logic oe);
      logic b;
      got = '0;
      SS  = 1'b0;
      wclk(8);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) x_pos = chg_x;
         xfer_bit(mo[63-i], b);
         got[63-i] = b;
      end
      wclk(4);
      oe = miso_oe;
      SS = 1'b1;
   endtask

   // Packet as bytes: X lo, X hi, Y lo, Y hi, buttons, then zeros for any extra bytes.
   function automatic logic [63:0] model_pkt(input logic [9:0] x, input logic [9:0] y, input logic [1:0] b);
      logic [63:0] p;
      p = '0;
      p[63:56] = 8'(x % 256);
      p[55:48] = 8'(x / 256);
      p[47:40] = 8'(y % 256);
      p[39:32] = 8'(y / 256);
      p[31:24] = 8'(b);
      return p;
   endfunction

   function automatic logic [63:0] mask(input int n);
      logic [63:0] all1;
      all1 = '1;
      return ~(all1 >> n);
   endfunction

   initial begin
      logic [63:0] got, got2, m, mo;
      logic        oe, b, quiet;
      int          d0, e0, l0, nb;
      logic [9:0]  rx, ry;
      logic [1:0]  rb;
      logic [23:0] model_led;

      tbl[0] = '{10'h2A5, 10'h0F3, 2'b10, 40, 64'h0,                  -1, 10'h0,   1, 0, 0, 24'h000000};
      tbl[1] = '{10'h2A5, 10'h0F3, 2'b10, 40, 64'h84FF800100_000000,  -1, 10'h0,   1, 0, 1, 24'hFF8001};
      tbl[2] = '{10'h123, 10'h321, 2'b01, 20, 64'h8411223300_000000,  -1, 10'h0,   0, 1, 0, 24'hFF8001};
      tbl[3] = '{10'h3FF, 10'h000, 2'b11, 48, 64'h0,                  20, 10'h155, 1, 0, 0, 24'hFF8001};
      tbl[4] = '{10'h155, 10'h2AA, 2'b00, 32, 64'h8412345600_000000,  -1, 10'h0,   0, 1, 1, 24'h123456};
      tbl[5] = '{10'h001, 10'h3FE, 2'b01, 39, 64'h84AABBCC00_000000,  -1, 10'h0,   0, 1, 0, 24'h123456};
      tbl[6] = '{10'h0AB, 10'h1CD, 2'b10, 40, 64'h85DDEEFF00_000000,  -1, 10'h0,   1, 0, 0, 24'h123456};
      tbl[7] = '{10'h200, 10'h100, 2'b11,  8, 64'h8400000000_000000,  -1, 10'h0,   0, 1, 0, 24'h123456};

      wclk(4);
      chk("rst_miso", MISO, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_led", led_rgb, 0);
      chk("rst_pulses", {led_valid, frame_done, frame_err}, 0);
      rst = 1'b0;
      wclk(6);

      for (int k = 0; k < 8; k++) begin
         x_pos = tbl[k].x; y_pos = tbl[k].y; btn = tbl[k].b;
         d0 = n_done; e0 = n_err; l0 = n_lv;
         run_frame(tbl[k].nbits, tbl[k].mo, tbl[k].chg_at, tbl[k].chg_x, got, oe);
         wclk(12);
         m = mask(tbl[k].nbits);
         chk($sformatf("v%0d_miso", k), got & m, model_pkt(tbl[k].x, tbl[k].y, tbl[k].b) & m);
         chk($sformatf("v%0d_oe_sel", k), oe, 1);
         chk($sformatf("v%0d_oe_idle", k), miso_oe, 0);
         chk($sformatf("v%0d_done", k), n_done - d0, tbl[k].exp_done);
         chk($sformatf("v%0d_err", k), n_err - e0, tbl[k].exp_err);
         chk($sformatf("v%0d_lv", k), n_lv - l0, tbl[k].exp_lv);
         chk($sformatf("v%0d_led", k), led_rgb, tbl[k].exp_led);
         if (k == 0) chk("v0_bytes", got[63:24], 40'hA502F30002);
      end

      // Back-to-back frames with a short SS-high gap.
      x_pos = 10'h2A5; y_pos = 10'h0F3; btn = 2'b10;
      d0 = n_done; e0 = n_err;
      run_frame(40, 64'h0, -1, 10'h0, got, oe);
      x_pos = 10'h1C3; y_pos = 10'h3A0; btn = 2'b01;
      wclk(8);
      run_frame(40, 64'h0, -1, 10'h0, got2, oe);
      wclk(12);
      chk("b2b_f1", got[63:24], 40'hA502F30002);
      chk("b2b_f2", got2 & mask(40), model_pkt(10'h1C3, 10'h3A0, 2'b01));
      chk("b2b_done", n_done - d0, 2);
      chk("b2b_err", n_err - e0, 0);

      // Reset in byte 2 with SS held low: outputs stay quiet until a fresh SS fall.
      x_pos = 10'h0F0; y_pos = 10'h00F; btn = 2'b11;
      SS = 1'b0;
      wclk(8);
      for (int i = 0; i < 12; i++) xfer_bit(1'b1, b);
      rst = 1'b1;
      wclk(2);
      rst = 1'b0;
      d0 = n_done; e0 = n_err; l0 = n_lv;
      quiet = 1'b1;
      for (int i = 0; i < 10; i++) begin
         xfer_bit(1'b1, b);
         if (b !== 1'b0 || miso_oe !== 1'b0) quiet = 1'b0;
      end
      SS = 1'b1;
      wclk(12);
      chk("rst_quiet", quiet, 1);
      chk("rst_nopulse", (n_done - d0) + (n_err - e0) + (n_lv - l0), 0);
      chk("rst_led_clr", led_rgb, 0);
      d0 = n_done;
      run_frame(40, 64'h0, -1, 10'h0, got, oe);
      wclk(12);
      chk("rst_next_frame", got & mask(40), model_pkt(10'h0F0, 10'h00F, 2'b11));
      chk("rst_next_done", n_done - d0, 1);

      // Random frames against the packet-level model.
      model_led = 24'h0;
      for (int k = 0; k < 20; k++) begin
         rx = 10'($urandom); ry = 10'($urandom); rb = 2'($urandom);
         nb = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 6) : $urandom_range(1, 48);
         mo = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) mo[63:56] = 8'h84;
         x_pos = rx; y_pos = ry; btn = rb;
         d0 = n_done; e0 = n_err; l0 = n_lv;
         run_frame(nb, mo, -1, 10'h0, got, oe);
         wclk(12);
         m = mask(nb);
         chk($sformatf("r%0d_miso", k), got & m, model_pkt(rx, ry, rb) & m);
         chk($sformatf("r%0d_done", k), n_done - d0, (nb % 8 == 0 && nb / 8 >= 5) ? 1 : 0);
         chk($sformatf("r%0d_err", k), n_err - e0, (nb % 8 == 0 && nb / 8 >= 5) ? 0 : 1);
         if (nb % 8 == 0 && nb / 8 >= 4 && mo[63:56] == 8'h84) begin
            model_led = mo[55:32];
            chk($sformatf("r%0d_lv", k), n_lv - l0, 1);
         end else begin
            chk($sformatf("r%0d_lv", k), n_lv - l0, 0);
         end
         chk($sformatf("r%0d_led", k), led_rgb, model_led);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
